// File: rtl/id_stage_rf_if.sv
// ID-stage bus: pipeline-control, register-write, forwarding and ID->EX signals.
// The IF/ID/control side is the master; the decode stage is the slave.
interface id_stage_rf_if #(
    parameter int FWD_N = 2,
    parameter int WR_N  = 1
);
    logic                   stall_in;
    logic                   flush;
    logic [31:0]            epc;
    logic [31:0]            id_pc;
    logic [31:0]            id_instr;
    logic [31:0]            id_exc;
    logic                   id_bd;
    logic                   id_use_rs;
    logic                   id_use_rt;
    logic [WR_N-1:0]        wr_en;
    logic [WR_N-1:0][4:0]   wr_addr;
    logic [WR_N-1:0][31:0]  wr_data;
    logic [FWD_N-1:0]       fwd_vld;
    logic [FWD_N-1:0]       fwd_rdy;
    logic [FWD_N-1:0][4:0]  fwd_addr;
    logic [FWD_N-1:0][31:0] fwd_data;
    logic                   stall_out;
    logic                   redirect;
    logic [31:0]            target;
    logic [31:0]            ex_rs;
    logic [31:0]            ex_rt;
    logic [31:0]            ex_instr;
    logic [31:0]            ex_pc;
    logic [31:0]            ex_exc;
    logic                   ex_bd;

    modport master (
        output stall_in, flush, epc, id_pc, id_instr, id_exc, id_bd, id_use_rs, id_use_rt,
               wr_en, wr_addr, wr_data, fwd_vld, fwd_rdy, fwd_addr, fwd_data,
        input  stall_out, redirect, target, ex_rs, ex_rt, ex_instr, ex_pc, ex_exc, ex_bd
    );

    modport slave (
        input  stall_in, flush, epc, id_pc, id_instr, id_exc, id_bd, id_use_rs, id_use_rt,
               wr_en, wr_addr, wr_data, fwd_vld, fwd_rdy, fwd_addr, fwd_data,
        output stall_out, redirect, target, ex_rs, ex_rt, ex_instr, ex_pc, ex_exc, ex_bd
    );
endinterface

// File: rtl/id_stage_rf.sv
// MIPS decode stage: register file, operand forwarding, load-use stall, branch resolution, ID->EX register.
// Define ID_EXT_BRANCH_EN to also resolve blez/bgtz/bltz/bgez/jalr.
module id_stage_rf #(
    parameter int FWD_N = 2,
    parameter int WR_N  = 1
) (
    input logic         clk,
    input logic         rst,
    id_stage_rf_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_ERET    = 6'b011000;
`ifdef ID_EXT_BRANCH_EN
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JALR    = 6'b001001;
`endif

    logic [31:0] regs [32];
    logic [4:0]  rs_idx, rt_idx;
    logic [5:0]  opcode, func;
    logic [31:0] rs_val, rt_val;
    logic        rs_hit, rt_hit, rs_rdy, rt_rdy;
    logic        s_eff, taken;
    logic [31:0] pc4, br_tgt, jmp_tgt, dest;

    assign opcode  = bus.id_instr[31:26];
    assign func    = bus.id_instr[5:0];
    assign rs_idx  = bus.id_instr[25:21];
    assign rt_idx  = bus.id_instr[20:16];
    assign pc4     = bus.id_pc + 32'd4;
    assign br_tgt  = pc4 + {{14{bus.id_instr[15]}}, bus.id_instr[15:0], 2'b00};
    assign jmp_tgt = {bus.id_pc[31:28], bus.id_instr[25:0], 2'b00};

    // Register 0 is never written, so after reset it always reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            for (int w = 0; w < WR_N; w++)
                if (bus.wr_en[w] && bus.wr_addr[w] != 5'd0)
                    regs[bus.wr_addr[w]] <= bus.wr_data[w];
        end
    end

    // Ascending write-port scan lets the highest port win; descending channel scan lets channel 0 win.
    always_comb begin
        rs_val = regs[rs_idx];
        rt_val = regs[rt_idx];
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_rdy = 1'b1;
        rt_rdy = 1'b1;
        for (int w = 0; w < WR_N; w++) begin
            if (bus.wr_en[w] && bus.wr_addr[w] == rs_idx && rs_idx != 5'd0) rs_val = bus.wr_data[w];
            if (bus.wr_en[w] && bus.wr_addr[w] == rt_idx && rt_idx != 5'd0) rt_val = bus.wr_data[w];
        end
        for (int c = FWD_N - 1; c >= 0; c--) begin
            if (bus.fwd_vld[c] && bus.fwd_addr[c] == rs_idx && rs_idx != 5'd0) begin
                rs_val = bus.fwd_data[c];
                rs_hit = 1'b1;
                rs_rdy = bus.fwd_rdy[c];
            end
            if (bus.fwd_vld[c] && bus.fwd_addr[c] == rt_idx && rt_idx != 5'd0) begin
                rt_val = bus.fwd_data[c];
                rt_hit = 1'b1;
                rt_rdy = bus.fwd_rdy[c];
            end
        end
    end

    assign bus.stall_out = (rs_hit && !rs_rdy && bus.id_use_rs) ||
                           (rt_hit && !rt_rdy && bus.id_use_rt);
    assign s_eff         = bus.stall_in | bus.stall_out;

    always_comb begin
        taken = 1'b0;
        dest  = pc4;
        case (opcode)
            OP_BEQ: begin
                taken = (rs_val == rt_val);
                dest  = br_tgt;
            end
            OP_BNE: begin
                taken = (rs_val != rt_val);
                dest  = br_tgt;
            end
            OP_J, OP_JAL: begin
                taken = 1'b1;
                dest  = jmp_tgt;
            end
            OP_SPECIAL: begin
`ifdef ID_EXT_BRANCH_EN
                if (func == FN_JR || func == FN_JALR) begin
`else
                if (func == FN_JR) begin
`endif
                    taken = 1'b1;
                    dest  = rs_val;
                end
            end
            OP_COP0: begin
                if (bus.id_instr[25] && func == FN_ERET) begin
                    taken = 1'b1;
                    dest  = bus.epc;
                end
            end
`ifdef ID_EXT_BRANCH_EN
            OP_BLEZ: begin
                taken = rs_val[31] || (rs_val == 32'd0);
                dest  = br_tgt;
            end
            OP_BGTZ: begin
                taken = !rs_val[31] && (rs_val != 32'd0);
                dest  = br_tgt;
            end
            OP_REGIMM: begin
                if (rt_idx == 5'd0) taken = rs_val[31];
                if (rt_idx == 5'd1) taken = !rs_val[31];
                dest = br_tgt;
            end
`endif
            default: ;
        endcase
    end

    assign bus.target   = taken ? dest : pc4;
    assign bus.redirect = taken && !rst && !s_eff;

    // A stall inserts a bubble that still carries the ID pc/bd so a later exception has a valid EPC.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_rs    <= '0;
            bus.ex_rt    <= '0;
            bus.ex_instr <= '0;
            bus.ex_pc    <= '0;
            bus.ex_exc   <= '0;
            bus.ex_bd    <= 1'b0;
        end else if (bus.flush) begin
            bus.ex_rs    <= '0;
            bus.ex_rt    <= '0;
            bus.ex_instr <= '0;
            bus.ex_exc   <= '0;
        end else if (s_eff) begin
            bus.ex_instr <= '0;
            bus.ex_exc   <= '0;
            bus.ex_pc    <= bus.id_pc;
            bus.ex_bd    <= bus.id_bd;
        end else begin
            bus.ex_rs    <= rs_val;
            bus.ex_rt    <= rt_val;
            bus.ex_instr <= bus.id_instr;
            bus.ex_pc    <= bus.id_pc;
            bus.ex_exc   <= bus.id_exc;
            bus.ex_bd    <= bus.id_bd;
        end
    end
endmodule

// File: tb/tb_id_stage_rf.sv
// Scoreboard bench for id_stage_rf (FWD_N=2, WR_N=2): each vector queues its expected same-cycle
// and next-edge results; a negedge monitor pops and compares.
module tb_id_stage_rf;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    typedef struct {
        string       name;
        bit          chk_comb;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] rs, rt, instr, pc, exc;
        logic        bd;
    } exp_t;

    exp_t sb_q [$];

    id_stage_rf_if #(.FWD_N(2), .WR_N(2)) bus ();

    id_stage_rf #(.FWD_N(2), .WR_N(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] off);
        return {op, rs, rt, off};
    endfunction

    function automatic logic [31:0] enc_jr(logic [4:0] rs);
        return {6'h00, rs, 15'h0000, 6'h08};
    endfunction

    function automatic exp_t mk(string n, logic st, logic rd, logic [31:0] tg, logic [31:0] rs,
                                logic [31:0] rt, logic [31:0] ins, logic [31:0] pc, logic [31:0] exc, logic bd);
        exp_t e;
        e.name = n; e.chk_comb = 1'b1; e.stall = st; e.redir = rd; e.target = tg;
        e.rs = rs; e.rt = rt; e.instr = ins; e.pc = pc; e.exc = exc; e.bd = bd;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0;
        bus.stall_in = 1'b0; bus.flush = 1'b0; bus.epc = '0;
        bus.id_pc = '0; bus.id_instr = '0; bus.id_exc = '0; bus.id_bd = 1'b0;
        bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.fwd_vld = '0; bus.fwd_rdy = '0; bus.fwd_addr = '0; bus.fwd_data = '0;
    endtask

    // Inputs for this cycle are already driven; queue the expectation and move to the next cycle.
    task automatic applyStimulus(input exp_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Same-cycle outputs belong to the popped entry; registered outputs to the previous one.
    initial begin
        exp_t cur, prev;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                cur = sb_q.pop_front();
                if (cur.chk_comb) begin
                    checkOutput({cur.name, ".stall_out"}, {31'd0, bus.stall_out}, {31'd0, cur.stall});
                    checkOutput({cur.name, ".redirect"}, {31'd0, bus.redirect}, {31'd0, cur.redir});
                    checkOutput({cur.name, ".target"}, bus.target, cur.target);
                end
                if (have_prev && prev.chk_comb) begin
                    checkOutput({prev.name, ".ex_rs"}, bus.ex_rs, prev.rs);
                    checkOutput({prev.name, ".ex_rt"}, bus.ex_rt, prev.rt);
                    checkOutput({prev.name, ".ex_instr"}, bus.ex_instr, prev.instr);
                    checkOutput({prev.name, ".ex_pc"}, bus.ex_pc, prev.pc);
                    checkOutput({prev.name, ".ex_exc"}, bus.ex_exc, prev.exc);
                    checkOutput({prev.name, ".ex_bd"}, {31'd0, bus.ex_bd}, {31'd0, prev.bd});
                end
                prev = cur;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        logic [31:0] ins;
        exp_t        dummy;
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset cycle: a pending write to r5 must be ignored, redirect suppressed.
        rst = 1'b1;
        ins = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
        bus.id_instr = ins; bus.id_pc = 32'h100;
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'h55;
        applyStimulus(mk("reset", 0, 0, 32'h108, 0, 0, 0, 0, 0, 0));

        ins = enc_i(6'h05, 5'd5, 5'd0, 16'd2);
        bus.id_instr = ins; bus.id_pc = 32'h200; bus.id_use_rs = 1;
        applyStimulus(mk("read_r5", 0, 0, 32'h204, 0, 0, ins, 32'h200, 0, 0));

        ins = enc_i(6'h04, 5'd8, 5'd8, 16'd4);
        bus.id_instr = ins; bus.id_pc = 32'h3000; bus.id_use_rs = 1; bus.id_use_rt = 1;
        bus.id_exc = 32'h10; bus.id_bd = 1;
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd8; bus.wr_data[0] = 32'h1234;
        applyStimulus(mk("bypass", 0, 1, 32'h3014, 32'h1234, 32'h1234, ins, 32'h3000, 32'h10, 1));

        ins = enc_i(6'h05, 5'd8, 5'd0, 16'hFFFF);
        bus.id_instr = ins; bus.id_pc = 32'h3010; bus.id_use_rs = 1;
        applyStimulus(mk("array_read", 0, 1, 32'h3010, 32'h1234, 0, ins, 32'h3010, 0, 0));

        ins = enc_jr(5'd10);
        bus.id_instr = ins; bus.id_pc = 32'h500; bus.id_use_rs = 1;
        bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd10; bus.wr_data[0] = 32'h111;
        bus.wr_addr[1] = 5'd10; bus.wr_data[1] = 32'h222;
        applyStimulus(mk("wr_same_addr", 0, 1, 32'h222, 32'h222, 0, ins, 32'h500, 0, 0));

        bus.id_instr = ins; bus.id_pc = 32'h504; bus.id_use_rs = 1;
        applyStimulus(mk("wr_high_wins", 0, 1, 32'h222, 32'h222, 0, ins, 32'h504, 0, 0));

        ins = enc_i(6'h05, 5'd9, 5'd0, 16'd1);
        bus.id_instr = ins; bus.id_pc = 32'h600; bus.id_use_rs = 1; bus.id_use_rt = 1;
        bus.fwd_vld = 2'b11; bus.fwd_rdy = 2'b11;
        bus.fwd_addr[0] = 5'd9; bus.fwd_data[0] = 32'hA;
        bus.fwd_addr[1] = 5'd9; bus.fwd_data[1] = 32'hB;
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'hC;
        applyStimulus(mk("fwd_priority", 0, 1, 32'h608, 32'hA, 0, ins, 32'h600, 0, 0));

        ins = enc_jr(5'd9);
        bus.id_instr = ins; bus.id_pc = 32'h700; bus.id_use_rs = 1;
        bus.fwd_vld = 2'b11; bus.fwd_rdy = 2'b11;
        bus.fwd_addr[0] = 5'd3; bus.fwd_data[0] = 32'h77;
        bus.fwd_addr[1] = 5'd9; bus.fwd_data[1] = 32'hB;
        applyStimulus(mk("fwd_ch1", 0, 1, 32'hB, 32'hB, 0, ins, 32'h700, 0, 0));

        ins = enc_i(6'h04, 5'd0, 5'd9, 16'd2);
        bus.id_instr = ins; bus.id_pc = 32'h800; bus.id_use_rs = 1; bus.id_use_rt = 1;
        bus.fwd_vld = 2'b01; bus.fwd_rdy = 2'b01; bus.fwd_addr[0] = 5'd0; bus.fwd_data[0] = 32'hDEAD;
        applyStimulus(mk("fwd_r0", 0, 0, 32'h804, 0, 32'hC, ins, 32'h800, 0, 0));

        ins = enc_jr(5'd4);
        bus.id_instr = ins; bus.id_pc = 32'h900; bus.id_use_rs = 1; bus.id_exc = 32'h20; bus.id_bd = 1;
        bus.fwd_vld = 2'b01; bus.fwd_rdy = 2'b00; bus.fwd_addr[0] = 5'd4; bus.fwd_data[0] = 32'h9999;
        applyStimulus(mk("load_use", 1, 0, 32'h9999, 0, 32'hC, 0, 32'h900, 0, 1));

        bus.id_instr = ins; bus.id_pc = 32'h900; bus.id_use_rs = 1;
        bus.fwd_vld = 2'b01; bus.fwd_rdy = 2'b01; bus.fwd_addr[0] = 5'd4; bus.fwd_data[0] = 32'h4000;
        applyStimulus(mk("load_done", 0, 1, 32'h4000, 32'h4000, 0, ins, 32'h900, 0, 0));

        bus.id_instr = ins; bus.id_pc = 32'hA00; bus.id_use_rs = 1;
        bus.fwd_vld = 2'b11; bus.fwd_rdy = 2'b01;
        bus.fwd_addr[0] = 5'd4; bus.fwd_data[0] = 32'h44;
        bus.fwd_addr[1] = 5'd4; bus.fwd_data[1] = 32'h55;
        applyStimulus(mk("older_ignored", 0, 1, 32'h44, 32'h44, 0, ins, 32'hA00, 0, 0));

        ins = enc_i(6'h05, 5'd6, 5'd0, 16'd1);
        bus.id_instr = ins; bus.id_pc = 32'hB00;
        bus.fwd_vld = 2'b01; bus.fwd_rdy = 2'b00; bus.fwd_addr[0] = 5'd6; bus.fwd_data[0] = 32'h66;
        applyStimulus(mk("no_use", 0, 1, 32'hB08, 32'h66, 0, ins, 32'hB00, 0, 0));

        ins = enc_i(6'h04, 5'd0, 5'd7, 16'd1);
        bus.id_instr = ins; bus.id_pc = 32'hC00; bus.id_use_rs = 1; bus.id_use_rt = 1;
        bus.fwd_vld = 2'b10; bus.fwd_rdy = 2'b00; bus.fwd_addr[1] = 5'd7; bus.fwd_data[1] = 32'h0;
        applyStimulus(mk("rt_hazard", 1, 0, 32'hC08, 32'h66, 0, 0, 32'hC00, 0, 0));

        bus.id_instr = 32'h42000018; bus.id_pc = 32'hD00; bus.epc = 32'h4180; bus.stall_in = 1;
        applyStimulus(mk("stall_in", 0, 0, 32'h4180, 32'h66, 0, 0, 32'hD00, 0, 0));

        ins = {6'h02, 26'h40};
        bus.id_instr = ins; bus.id_pc = 32'hE00; bus.flush = 1; bus.stall_in = 1;
        bus.id_bd = 1; bus.id_exc = 32'h30;
        applyStimulus(mk("flush_stall", 0, 0, 32'h100, 0, 0, 0, 32'hD00, 0, 0));

        bus.id_instr = 32'h42000018; bus.id_pc = 32'hF00; bus.epc = 32'h4180;
        applyStimulus(mk("eret", 0, 1, 32'h4180, 0, 0, 32'h42000018, 32'hF00, 0, 0));

        ins = {6'h03, 26'h123};
        bus.id_instr = ins; bus.id_pc = 32'h3000_0010;
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd2; bus.wr_data[0] = 32'hFFFF_FFFF;
        applyStimulus(mk("jal", 0, 1, 32'h3000_048C, 0, 0, ins, 32'h3000_0010, 0, 0));

        ins = enc_i(6'h07, 5'd2, 5'd0, 16'd4);
        bus.id_instr = ins; bus.id_pc = 32'h2000; bus.id_use_rs = 1;
        applyStimulus(mk("bgtz_neg", 0, 0, 32'h2004, 32'hFFFF_FFFF, 0, ins, 32'h2000, 0, 0));

        ins = enc_i(6'h06, 5'd2, 5'd0, 16'd4);
        bus.id_instr = ins; bus.id_pc = 32'h2100; bus.id_use_rs = 1;
`ifdef ID_EXT_BRANCH_EN
        applyStimulus(mk("blez_neg", 0, 1, 32'h2114, 32'hFFFF_FFFF, 0, ins, 32'h2100, 0, 0));
`else
        applyStimulus(mk("blez_neg", 0, 0, 32'h2104, 32'hFFFF_FFFF, 0, ins, 32'h2100, 0, 0));
`endif

        rst = 1'b1;
        ins = enc_jr(5'd4);
        bus.id_instr = ins; bus.id_pc = 32'h2200; bus.id_use_rs = 1;
        bus.fwd_vld = 2'b01; bus.fwd_rdy = 2'b00; bus.fwd_addr[0] = 5'd4; bus.fwd_data[0] = 32'h5;
        applyStimulus(mk("reset_stall", 1, 0, 32'h5, 0, 0, 0, 0, 0, 0));

        ins = enc_jr(5'd2);
        bus.id_instr = ins; bus.id_pc = 32'h2300; bus.id_use_rs = 1;
        applyStimulus(mk("rf_cleared", 0, 1, 32'h0, 0, 0, ins, 32'h2300, 0, 0));

        dummy = mk("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dummy.chk_comb = 1'b0;
        applyStimulus(dummy);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_stage_rf.md
# id_stage_rf

Parametrised decode stage for the MIPS pipeline: integer register file with WR_N write ports, FWD_N forwarding channels, in-stage branch/jump resolution with same-cycle redirect to IF, internal load-use hazard detection, and the ID->EX pipeline register carrying exception code and branch-delay flag. It sits between IF and EX and replaces the fixed single-write, externally-stalled decode stage.

## Interface
- FWD_N, 2, forwarding channels; channel 0 = youngest stage (EX), higher = older
- WR_N, 1, register-file write ports; higher index wins on same address
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_in  in  1  external stall (e.g. mul/div busy)
- flush  in  1  exception/interrupt flush request
- epc  in  32  CP0 EPC for eret
- id_pc, id_instr  in  32 each  instruction in ID
- id_exc  in  32  exception code from IF; id_bd  in  1  delay-slot flag
- id_use_rs, id_use_rt  in  1 each  operand required in ID (from controller decode)
- wr_en  in  WR_N  write enables; wr_addr  in  5*WR_N; wr_data  in  32*WR_N
- fwd_vld  in  FWD_N  channel holds pending write; fwd_rdy  in  FWD_N  its data is available
- fwd_addr  in  5*FWD_N; fwd_data  in  32*FWD_N
- stall_out  out  1  hazard stall to IF/ID
- redirect  out  1  take target this cycle; target  out  32  next PC
- ex_rs, ex_rt  out  32 each; ex_instr, ex_pc, ex_exc  out  32 each; ex_bd  out  1

## Operation
- 32 x 32 register file; register 0 reads 0, writes to it ignored.
- Operand resolution for rs and rt independently, priority: lowest-index forwarding channel with fwd_vld=1, addr match, addr!=0; else highest-index write port with wr_en=1, addr match, addr!=0 (internal bypass); else array.
- Hazard: matched channel (first by priority) has fwd_rdy=0 and corresponding id_use_x=1 -> stall_out=1. Older channels are not consulted once a younger match exists.
- Effective stall S = stall_in | stall_out.
- Branch decode (opcode/func as in const.v): beq (rs==rt), bne (rs!=rt) -> pc+4+sext(offset)<<2; j, jal -> {pc[31:28],index,2'b00}; jr -> rs; eret -> epc. Otherwise target = pc+4, redirect=0.
- redirect forced 0 when rst or S; target still computed.
- Pipeline register priority rst > flush > S > normal:
  - rst: all ex_* = 0, register file cleared.
  - flush: ex_rs, ex_rt, ex_instr, ex_exc <= 0; ex_pc, ex_bd hold.
  - S: bubble: ex_instr, ex_exc <= 0; ex_pc <= id_pc, ex_bd <= id_bd (EPC source for bubble); ex_rs, ex_rt hold.
  - normal: ex_rs/ex_rt <= resolved operands, ex_instr/ex_pc/ex_exc/ex_bd <= ID inputs.
- Register-file writes occur in every non-reset cycle regardless of flush/S.

## Timing
- stall_out, redirect, target: combinational, same cycle as inputs.
- ex_* : 1-cycle latency, update at posedge.
- Write on cycle N visible in array at N+1; bypass makes it visible to ID reads on cycle N.
- Simultaneous flush and stall: flush wins. Reset mid-stall: all state cleared next edge, stall_out follows inputs immediately.
- Two write ports, same address, same cycle: highest index written and bypassed.

## Configuration
- ID_EXT_BRANCH_EN defined: additionally resolves blez (rs<=0 signed), bgtz (rs>0), REGIMM bltz/bgez (rt field 0/1), jalr (target rs); these use rs and participate in hazard via id_use_rs.
- Undefined: those encodings produce redirect=0, target=pc+4.

## Test plan
- Reset: rst=1 one cycle -> all ex_*=0, read of r5 = 0, redirect=0.
- Bypass: wr_en=1, wr_addr=8, wr_data=0x1234; id_instr beq r8,r8,+4 at pc 0x3000 -> redirect=1, target=0x3014 same cycle.
- Forward priority: ch0 vld rdy addr 9 data 0xA, ch1 vld rdy addr 9 data 0xB, bne r9,r0 -> ex_rs=0xA next edge, redirect=1.
- Load-use: ch0 vld=1 rdy=0 addr 4, jr r4 with id_use_rs=1 -> stall_out=1, redirect=0, ex_instr=0, ex_pc=id_pc; rdy=1 next cycle -> target=fwd_data.
- Flush vs stall: flush=1, stall_in=1 -> ex_instr=0, ex_exc=0, ex_pc unchanged.
- eret with epc=0x4180 -> redirect=1, target=0x4180; with ID_EXT_BRANCH_EN, bgtz r2 (r2=-1) -> redirect=0.
